// File: rtl/op2_shift_pipe.sv
// ----------------------------------------------------------------------------
// op2_shift_pipe
// Two-stage pipelined ARM data-processing operand-2 shifter with a
// valid/ready handshake and flush.
//
// Stage 1 registers the request together with a decoded operation kind, an
// amount class (zero / below WIDTH / equal to WIDTH / above WIDTH) and the
// rotate index. Stage 2 registers the shifted result and the carry-out.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   flush        drop every in-flight operation at this edge
//   in_valid     request valid
//   in_ready     block can accept a request this cycle
//   in_operand   Rm value, or zero-extended 8-bit immediate when in_imm=1
//   in_amount    shift amount (Rs bits, or 5-bit immediate field, or rotate
//                field in [3:0] when in_imm=1)
//   in_mode      00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX (ignored when in_imm=1)
//   in_amt_reg   amount is register-specified
//   in_imm       immediate-operand form, rotate right by 2*in_amount[3:0]
//   in_c         current C flag
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_result   shifted operand
//   out_c        shifter carry-out
// ----------------------------------------------------------------------------
module op2_shift_pipe #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_operand,
   input  logic [AMT_W-1:0] in_amount,
   input  logic [1:0]       in_mode,
   input  logic             in_amt_reg,
   input  logic             in_imm,
   input  logic             in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_c
);

   localparam int LOGW = $clog2(WIDTH);

   // Operation actually performed in stage 2 once the #0 encodings and the
   // immediate form have been resolved.
   typedef enum logic [2:0] {
      K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX, K_IMM
   } kind_e;

   typedef enum logic [1:0] {
      C_ZERO, C_LT, C_EQ, C_GT
   } amt_class_e;

   // ---------------------------------------------------------------- stage 1
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_op_q;
   logic             s1_c_q;
   kind_e            s1_kind_q,  s1_kind_d;
   amt_class_e       s1_class_q, s1_class_d;
   logic [LOGW-1:0]  s1_rot_q,   s1_rot_d;

   logic [31:0]      amt_ext;
   logic [31:0]      imm_rot;

   // The full amount is classified against WIDTH before any truncation.
   assign amt_ext = 32'(in_amount);
   assign imm_rot = {27'b0, in_amount[3:0], 1'b0};

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case/if tree can leave it unassigned (no latch).
   always_comb begin
      s1_kind_d  = K_PASS;
      s1_class_d = C_ZERO;
      s1_rot_d   = '0;
      if (in_imm) begin
         if (imm_rot != 32'd0) begin
            s1_kind_d = K_IMM;
            s1_rot_d  = imm_rot[LOGW-1:0];
         end
      end else if (amt_ext == 32'd0) begin
         // Register amount of zero and LSL #0 pass the operand through.
         if (!in_amt_reg) begin
            case (in_mode)
               2'b01:   begin s1_kind_d = K_LSR; s1_class_d = C_EQ; end
               2'b10:   begin s1_kind_d = K_ASR; s1_class_d = C_EQ; end
               2'b11:   s1_kind_d = K_RRX;
               default: s1_kind_d = K_PASS;
            endcase
         end
      end else begin
         case (in_mode)
            2'b00:   s1_kind_d = K_LSL;
            2'b01:   s1_kind_d = K_LSR;
            2'b10:   s1_kind_d = K_ASR;
            default: s1_kind_d = K_ROR;
         endcase
         if (amt_ext < 32'(WIDTH))       s1_class_d = C_LT;
         else if (amt_ext == 32'(WIDTH)) s1_class_d = C_EQ;
         else                            s1_class_d = C_GT;
         // n mod WIDTH: the rotate index, and the shift distance when n<WIDTH.
         s1_rot_d = in_amount[LOGW-1:0];
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic             s2_c_q,      s2_c_d;

   logic [LOGW:0]    r_inv;
   logic [LOGW-1:0]  r_m1;
   logic [WIDTH-1:0] rotated;

   assign r_inv   = (LOGW+1)'(WIDTH) - {1'b0, s1_rot_q};
   assign r_m1    = s1_rot_q - LOGW'(1);
   // With r=0 the left shift is by WIDTH and contributes nothing.
   assign rotated = (s1_op_q >> s1_rot_q) | (s1_op_q << r_inv);

   always_comb begin
      s2_result_d = s1_op_q;
      s2_c_d      = s1_c_q;
      case (s1_kind_q)
         K_LSL: begin
            case (s1_class_q)
               C_LT: begin
                  s2_result_d = s1_op_q << s1_rot_q;
                  s2_c_d      = s1_op_q[r_inv[LOGW-1:0]];
               end
               C_EQ: begin s2_result_d = '0; s2_c_d = s1_op_q[0]; end
               C_GT: begin s2_result_d = '0; s2_c_d = 1'b0;       end
               default: ;
            endcase
         end
         K_LSR: begin
            case (s1_class_q)
               C_LT: begin
                  s2_result_d = s1_op_q >> s1_rot_q;
                  s2_c_d      = s1_op_q[r_m1];
               end
               C_EQ: begin s2_result_d = '0; s2_c_d = s1_op_q[WIDTH-1]; end
               C_GT: begin s2_result_d = '0; s2_c_d = 1'b0;             end
               default: ;
            endcase
         end
         K_ASR: begin
            if (s1_class_q == C_LT) begin
               s2_result_d = WIDTH'($signed(s1_op_q) >>> s1_rot_q);
               s2_c_d      = s1_op_q[r_m1];
            end else begin
               s2_result_d = {WIDTH{s1_op_q[WIDTH-1]}};
               s2_c_d      = s1_op_q[WIDTH-1];
            end
         end
         // For a rotate the carry is always the result MSB: op[r-1] for r!=0,
         // op[WIDTH-1] for r=0.
         K_ROR, K_IMM: begin
            s2_result_d = rotated;
            s2_c_d      = rotated[WIDTH-1];
         end
         K_RRX: begin
            s2_result_d = {s1_c_q, s1_op_q[WIDTH-1:1]};
            s2_c_d      = s1_op_q[0];
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------- handshake
   logic s2_load;
   logic accept;

   assign s2_load  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_c_q      <= 1'b0;
      end else if (flush) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_result_q <= s2_result_d;
               s2_c_q      <= s2_c_d;
            end
         end
         if (in_ready) s1_valid_q <= in_valid;
      end
   end

   // NOTE: the stage-1 payload has no reset; it is only observed behind
   // s1_valid_q, so resetting it would buy nothing.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op_q    <= in_operand;
         s1_c_q     <= in_c;
         s1_kind_q  <= s1_kind_d;
         s1_class_q <= s1_class_d;
         s1_rot_q   <= s1_rot_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_c      = s2_c_q;

endmodule

// File: tb/tb_op2_shift_pipe.sv
// ----------------------------------------------------------------------------
// tb_op2_shift_pipe
// Self-checking bench for op2_shift_pipe: a directed vector table run on a
// 32-bit and a 16-bit instance, hand-written backpressure and flush
// sequences, and a randomized stream scored against a bit-serial reference
// model (each shift step moves one bit; the carry is the last bit moved out).
// ----------------------------------------------------------------------------
module tb_op2_shift_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // 32-bit instance
   logic        flush = 1'b0, in_valid = 1'b0, in_ready;
   logic [31:0] in_operand = '0;
   logic [7:0]  in_amount = '0;
   logic [1:0]  in_mode = '0;
   logic        in_amt_reg = 1'b0, in_imm = 1'b0, in_c = 1'b0;
   logic        out_valid, out_ready = 1'b1, out_c;
   logic [31:0] out_result;

   // 16-bit instance
   logic        flush16 = 1'b0, in_valid16 = 1'b0, in_ready16;
   logic [15:0] in_operand16 = '0;
   logic [7:0]  in_amount16 = '0;
   logic [1:0]  in_mode16 = '0;
   logic        in_amt_reg16 = 1'b0, in_imm16 = 1'b0, in_c16 = 1'b0;
   logic        out_valid16, out_ready16 = 1'b1, out_c16;
   logic [15:0] out_result16;

   op2_shift_pipe #(.WIDTH(32), .AMT_W(8)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_operand(in_operand), .in_amount(in_amount), .in_mode(in_mode),
      .in_amt_reg(in_amt_reg), .in_imm(in_imm), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_c(out_c)
   );

   op2_shift_pipe #(.WIDTH(16), .AMT_W(8)) u_dut16 (
      .clk(clk), .rst(rst), .flush(flush16),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .in_operand(in_operand16), .in_amount(in_amount16), .in_mode(in_mode16),
      .in_amt_reg(in_amt_reg16), .in_imm(in_imm16), .in_c(in_c16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .out_result(out_result16), .out_c(out_c16)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: shifts one bit position per step.
   function automatic void ref_shift(
      input  logic [63:0] op_in, input logic [7:0] amt, input logic [1:0] mode,
      input  logic amt_reg, input logic imm, input logic cin, input int w,
      output logic [63:0] res, output logic cout);
      logic [63:0] mask, v;
      logic        c;
      int          n;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      v    = op_in & mask;
      c    = cin;
      if (imm) begin
         n = 2 * int'(amt[3:0]);
         for (int i = 0; i < n; i++) v = ((v >> 1) | (64'(v[0]) << (w - 1))) & mask;
         res  = v;
         cout = (n == 0) ? cin : v[w-1];
         return;
      end
      n = int'(amt);
      if (n == 0) begin
         if (amt_reg || mode == 2'b00) begin res = v; cout = cin; return; end
         if (mode == 2'b11) begin
            res  = (v >> 1) | (64'(cin) << (w - 1));
            cout = v[0];
            return;
         end
         n = w;
      end
      for (int i = 0; i < n; i++) begin
         case (mode)
            2'b00:   begin c = v[w-1]; v = (v << 1) & mask; end
            2'b01:   begin c = v[0];   v = v >> 1; end
            2'b10:   begin c = v[0];   v = (v >> 1) | (64'(v[w-1]) << (w - 1)); end
            default: v = (v >> 1) | (64'(v[0]) << (w - 1));
         endcase
      end
      if (mode == 2'b11) c = v[w-1];
      res  = v;
      cout = c;
   endfunction

   typedef struct {
      string       name;
      bit          w16;
      logic [31:0] op;
      logic [7:0]  amt;
      logic [1:0]  mode;
      logic        amt_reg;
      logic        imm;
      logic        cin;
      logic [31:0] exp_res;
      logic        exp_c;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input bit w16, input logic [31:0] op,
                      input logic [7:0] amt, input logic [1:0] mode,
                      input logic amt_reg, input logic imm, input logic cin,
                      input logic [31:0] exp_res, input logic exp_c);
      vec_t v;
      v.name = name; v.w16 = w16; v.op = op; v.amt = amt; v.mode = mode;
      v.amt_reg = amt_reg; v.imm = imm; v.cin = cin;
      v.exp_res = exp_res; v.exp_c = exp_c;
      vecs.push_back(v);
   endtask

   // One isolated request: accepted at the first edge, visible two edges on.
   task automatic apply_vec(input vec_t v);
      @(posedge clk); #1;
      if (v.w16) begin
         in_valid16 = 1'b1; in_operand16 = v.op[15:0]; in_amount16 = v.amt;
         in_mode16 = v.mode; in_amt_reg16 = v.amt_reg; in_imm16 = v.imm;
         in_c16 = v.cin;
      end else begin
         in_valid = 1'b1; in_operand = v.op; in_amount = v.amt;
         in_mode = v.mode; in_amt_reg = v.amt_reg; in_imm = v.imm;
         in_c = v.cin;
      end
      @(negedge clk);
      check({v.name, "/in_ready"}, v.w16 ? in_ready16 : in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid16 = 1'b0;
      @(negedge clk);
      check({v.name, "/early"}, v.w16 ? out_valid16 : out_valid, 1'b0);
      @(negedge clk);
      check({v.name, "/valid"}, v.w16 ? out_valid16 : out_valid, 1'b1);
      check({v.name, "/result"}, v.w16 ? 64'(out_result16) : 64'(out_result),
            64'(v.exp_res));
      check({v.name, "/c"}, v.w16 ? out_c16 : out_c, v.exp_c);
   endtask

   task automatic drive_req(input logic [31:0] op, input logic [7:0] amt,
                            input logic [1:0] mode, input logic amt_reg,
                            input logic imm, input logic cin);
      in_operand = op; in_amount = amt; in_mode = mode;
      in_amt_reg = amt_reg; in_imm = imm; in_c = cin;
   endtask

   logic [32:0] exp_q[$];

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      int          sent, got, seen;
      logic        hold_chk;
      logic [32:0] hold_val, e;
      logic [63:0] mres;
      logic        mc;

      //              name         w16 op            amt    mode reg imm c  exp_res        exp_c
      add("lsl_r1",      0, 32'h8000_0001, 8'd1,   2'b00, 1, 0, 0, 32'h0000_0002, 1'b1);
      add("lsr_i0",      0, 32'h8000_0003, 8'd0,   2'b01, 0, 0, 1, 32'h0000_0000, 1'b1);
      add("asr_i0",      0, 32'h8000_0003, 8'd0,   2'b10, 0, 0, 1, 32'hFFFF_FFFF, 1'b1);
      add("rrx",         0, 32'h8000_0003, 8'd0,   2'b11, 0, 0, 1, 32'hC000_0001, 1'b1);
      add("lsl_i0",      0, 32'h0000_1234, 8'd0,   2'b00, 0, 0, 1, 32'h0000_1234, 1'b1);
      add("lsl_r32",     0, 32'h0000_0001, 8'd32,  2'b00, 1, 0, 0, 32'h0000_0000, 1'b1);
      add("lsl_r33",     0, 32'h0000_0001, 8'd33,  2'b00, 1, 0, 0, 32'h0000_0000, 1'b0);
      add("ror_r64",     0, 32'h0000_0001, 8'd64,  2'b11, 1, 0, 1, 32'h0000_0001, 1'b0);
      add("reg_n0",      0, 32'h0000_0001, 8'd0,   2'b10, 1, 0, 1, 32'h0000_0001, 1'b1);
      add("imm_rot8",    0, 32'h0000_00FF, 8'd4,   2'b00, 0, 1, 0, 32'hFF00_0000, 1'b1);
      add("imm_rot0",    0, 32'h0000_00FF, 8'd0,   2'b00, 0, 1, 0, 32'h0000_00FF, 1'b0);
      add("lsr_r4",      0, 32'h0000_00F8, 8'd4,   2'b01, 1, 0, 0, 32'h0000_000F, 1'b1);
      add("asr_r4",      0, 32'h8000_0000, 8'd4,   2'b10, 1, 0, 1, 32'hF800_0000, 1'b0);
      add("lsr_r32",     0, 32'h8000_0000, 8'd32,  2'b01, 1, 0, 0, 32'h0000_0000, 1'b1);
      add("lsr_r33",     0, 32'h8000_0000, 8'd33,  2'b01, 1, 0, 1, 32'h0000_0000, 1'b0);
      add("asr_r200",    0, 32'h8000_0000, 8'd200, 2'b10, 1, 0, 0, 32'hFFFF_FFFF, 1'b1);
      add("ror_r8",      0, 32'h0000_00AB, 8'd8,   2'b11, 1, 0, 0, 32'hAB00_0000, 1'b1);
      add("w16_lsl16",   1, 32'h0000_0001, 8'd16,  2'b00, 1, 0, 0, 32'h0000_0000, 1'b1);
      add("w16_lsl17",   1, 32'h0000_0001, 8'd17,  2'b00, 1, 0, 0, 32'h0000_0000, 1'b0);
      add("w16_ror32",   1, 32'h0000_0001, 8'd32,  2'b11, 1, 0, 1, 32'h0000_0001, 1'b0);
      add("w16_n0",      1, 32'h0000_0001, 8'd0,   2'b01, 1, 0, 1, 32'h0000_0001, 1'b1);
      add("w16_asr16",   1, 32'h0000_8000, 8'd16,  2'b10, 1, 0, 0, 32'h0000_FFFF, 1'b1);

      // ---- reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst/out_valid",  out_valid,  1'b0);
      check("rst/out_result", out_result, 32'h0);
      check("rst/out_c",      out_c,      1'b0);
      check("rst/in_ready",   in_ready,   1'b1);
      check("rst/out_valid16", out_valid16, 1'b0);

      // ---- directed table
      foreach (vecs[i]) apply_vec(vecs[i]);

      // ---- backpressure: 4 back-to-back requests, consumer stalled 3 cycles
      sent = 0; got = 0; hold_chk = 1'b0; hold_val = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk); #1;
         in_valid = (sent < 4);
         drive_req(32'(sent + 1), 8'd1, 2'b00, 1'b1, 1'b0, 1'b0);
         out_ready = (cyc >= 5);
         @(negedge clk);
         if (cyc == 2) check("bp/in_ready_full", in_ready, 1'b0);
         if (hold_chk) check("bp/hold", {out_valid, out_c, out_result}, {1'b1, hold_val});
         if (out_valid && out_ready) begin
            if (got < 4) check("bp/order", out_result, 32'(2 * (got + 1)));
            got++;
         end
         if (in_valid && in_ready) sent++;
         hold_chk = out_valid && !out_ready;
         hold_val = {out_c, out_result};
      end
      in_valid = 1'b0;
      check("bp/delivered", got, 4);

      // ---- flush with both stages full and a new request offered
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      drive_req(32'h0000_0011, 8'd2, 2'b00, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive_req(32'h0000_0022, 8'd2, 2'b00, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive_req(32'h0000_0033, 8'd2, 2'b00, 1'b1, 1'b0, 1'b0);
      flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("fl/out_valid_before", out_valid, 1'b1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("fl/out_valid_after", out_valid, 1'b0);
      check("fl/in_ready_after",  in_ready,  1'b1);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("fl/none_emerge", seen, 0);

      // ---- randomized stream against the reference model
      hold_chk = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 64) == 0;
         in_operand = $urandom;
         in_mode    = 2'($urandom);
         in_amt_reg = 1'($urandom);
         in_imm     = ($urandom % 5) == 0;
         in_c       = 1'($urandom);
         if (in_imm)           in_amount = 8'($urandom % 16);
         else if (!in_amt_reg) in_amount = 8'($urandom % 32);
         else if ($urandom % 4 == 0) in_amount = 8'($urandom);
         else                  in_amount = 8'($urandom_range(0, 40));
         @(negedge clk);
         if (hold_chk) check("rnd/hold", {out_valid, out_c, out_result}, {1'b1, hold_val});
         if (flush) begin
            exp_q.delete();
            hold_chk = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("rnd/spurious", 1'b1, 1'b0);
               else begin
                  e = exp_q.pop_front();
                  check("rnd/result", {out_c, out_result}, e);
               end
            end
            if (in_valid && in_ready) begin
               ref_shift(64'(in_operand), in_amount, in_mode, in_amt_reg, in_imm,
                         in_c, 32, mres, mc);
               exp_q.push_back({mc, mres[31:0]});
            end
            hold_chk = out_valid && !out_ready;
            hold_val = {out_c, out_result};
         end
      end

      // ---- drain
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            check("rnd/drain_result", {out_c, out_result}, e);
         end
      end
      check("rnd/drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/op2_shift_pipe.md
Name: op2_shift_pipe

Overview:
- Pipelined, parametrised ARM data-processing operand-2 shifter: next generation of the combinational operand-2 shifter in the decoder path.
- Adds configurable datapath width and a valid/ready handshake with a 2-stage pipeline and flush.
- Full ARM shifter semantics: RRX, the immediate #0 encodings, correct carry-out for every mode, and register amounts ≥ WIDTH.
- Sits between the register-read stage and the ALU; consumes already-read operand values, not register indices.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- AMT_W, 8, width of the register-specified shift amount (ARM uses Rs[7:0]).
- LOGW, $clog2(WIDTH), derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop all in-flight operations this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept the request this cycle.
- in_operand  in  WIDTH  Rm value, or zero-extended 8-bit immediate when in_imm=1.
- in_amount  in  AMT_W  shift amount: Rs[AMT_W-1:0] if in_amt_reg=1, else the 5-bit immediate field (upper bits 0); rotate field when in_imm=1.
- in_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX; ignored when in_imm=1.
- in_amt_reg  in  1  amount is register-specified.
- in_imm  in  1  immediate-operand form: rotate right by 2*in_amount[3:0].
- in_c  in  1  current CPSR C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  shifted operand.
- out_c  out  1  shifter carry-out.

Behaviour:
- Reset (rst=1 at a clk edge): both stage valids = 0, out_valid=0, out_result=0, out_c=0. in_ready=1 in the cycle after reset.
- Pipeline:
  - S1 registers the request and a normalised amount class: zero, lt (1..W-1), eq (W), gt (>W), plus the rotate index n mod W.
  - S2 registers result and carry.
  - Latency is 2 cycles from in_valid&&in_ready to out_valid with no stalls.
  - Throughput is 1 per cycle.
- Handshake:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid || S2 loads.
  - Outputs are held stable while out_valid && !out_ready.
  - in_ready must not depend combinationally on in_valid.
- flush: clears S1_valid and S2_valid at the edge. A request presented in the same cycle as flush is discarded. flush has priority over all loads.
- Immediate-amount encodings (in_amt_reg=0, in_imm=0), n=in_amount:
  - LSL #0: result=operand, c=in_c.
  - LSR #0: treat as LSR #W.
  - ASR #0: treat as ASR #W.
  - ROR #0: RRX, result={in_c, op[W-1:1]}, c=op[0].
- Register amounts (in_amt_reg=1), n=in_amount[AMT_W-1:0]:
  - n=0: result=operand, c=in_c, for all modes.
- Shift results for n≥1 (from either encoding):
  - LSL: n<W gives op<<n, c=op[W-n]. n=W gives 0, c=op[0]. n>W gives 0, c=0.
  - LSR: n<W gives op>>n, c=op[n-1]. n=W gives 0, c=op[W-1]. n>W gives 0, c=0.
  - ASR: n<W gives arithmetic shift, c=op[n-1]. n≥W gives all bits = op[W-1], c=op[W-1].
  - ROR, with r = n mod W: r=0 gives result=op, c=op[W-1]. r≠0 gives rotate right by r, c=op[r-1].
- Immediate operand (in_imm=1): rot=2*in_amount[3:0]; result = in_operand rotated right by rot.
  - rot=0: c=in_c.
  - rot≠0: c=result[W-1].
- Amount arithmetic: compare the full AMT_W bits against W; no truncation before classification.
- Simultaneous events:
  - rst dominates flush, and flush dominates handshake.
  - An accept and a drain in the same cycle with S1 full is a legal full-rate pass-through.

Test Plan:
1. Reset, then one request: LSL reg, op=0x8000_0001, n=1, in_c=0 -> after 2 cycles out_valid=1, result=0x0000_0002, c=1.
2. Immediate #0 encodings, op=0x8000_0003, in_c=1:
   - LSR #0 -> 0, c=1.
   - ASR #0 -> 0xFFFF_FFFF, c=1.
   - ROR #0 (RRX) -> 0xC000_0001, c=1.
3. Register amounts ≥ W, op=0x0000_0001:
   - LSL n=32 -> 0, c=1.
   - LSL n=33 -> 0, c=0.
   - ROR n=64 -> 0x0000_0001, c=0.
   - n=0 with in_c=1 -> op, c=1.
4. Immediate form: imm=0xFF, rot field=4 (ROR 8) -> 0xFF00_0000, c=1; rot field=0, in_c=0 -> 0x0000_00FF, c=0.
5. Backpressure: stream 4 back-to-back requests, hold out_ready=0 for 3 cycles -> result held stable, in_ready=0 after S1 fills, all 4 delivered in order with none lost or duplicated.
6. flush while both stages are full and a new request is offered -> next cycle out_valid=0, none of the 3 results emerge; WIDTH=16 re-run of scenario 3 with n=16/17 gives the analogous values.
